// File: rtl/fpu_arith_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_arith_ctrl
//
// Purpose:
//   Issue/response controller that sits directly upstream of the FPU
//   arithmetic top. It accepts one FP operation at a time from the core,
//   registers the operands, op and resolved rounding mode, and holds
//   fpu_start high until the FPU signals fpu_done. It then returns the result
//   and exception flags on a response channel. It also owns the sticky
//   fflags and frm fields of fcsr.
//
// Handshakes (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer keeps valid and its payload stable until that edge. The
//   consumer may change ready at any time. ready does not depend
//   combinationally on valid.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request channel (req_ready = 1 only in IDLE)
//   req_op, req_rm,            FPU op code, funct3/rm field,
//   req_rs2_lsb                signed/unsigned select for conversions
//   req_a, req_b               operands A and B
//   resp_valid / resp_ready    response channel
//   resp_data, resp_flags      result and {NV,DZ,OF,UF,NX} of this op
//   resp_illegal               op rejected because of a bad rounding mode
//   resp_timeout               op aborted by the busy-cycle watchdog
//   flush                      abort the in-flight op or pending response
//   fpu_*                      registered command to the FPU, plus its
//                              combinational done/result/flag return
//   csr_fflags_we, csr_frm_we  fcsr write strobes
//   csr_wdata                  {frm, fflags} write data
//   fflags, frm                sticky accrued flags, dynamic rounding mode
// ---------------------------------------------------------------------------
module fpu_arith_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic        req_rs2_lsb,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_flags,
    output logic        resp_illegal,
    output logic        resp_timeout,
    input  logic        flush,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    input  logic        fpu_invalid,
    input  logic        fpu_inexact,
    input  logic        fpu_div_by_zero,
    input  logic        csr_fflags_we,
    input  logic        csr_frm_we,
    input  logic [7:0]  csr_wdata,
    output logic [4:0]  fflags,
    output logic [2:0]  frm
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // The counter is incremented on the edge that fires the watchdog, so the
    // check is made one count early. That gives 2**TIMEOUT_W-1 BUSY cycles.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state_q, state_d;
    logic [4:0]           op_q, op_d;
    logic [2:0]           rm_q, rm_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic                 rs2_q, rs2_d;
    logic [31:0]          data_q, data_d;
    logic [4:0]           flags_q, flags_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic [4:0]           fflags_q, fflags_d;
    logic [2:0]           frm_q, frm_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    logic       is_round;
    logic       rm_illegal;
    logic [2:0] rm_resolved;
    logic       capture;
    logic [4:0] fpu_flags;

    always_comb begin
        fpu_flags = {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact};

        // Only ops that round interpret rm as a rounding mode. For the other
        // ops (SGNJ, MINMAX, CMP, CLASS/MV) rm is a sub-op selector and passes
        // through unchanged. Resolution uses frm_q, so a frm write in the
        // accept cycle does not affect that request.
        is_round    = req_op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                     5'b01011, 5'b11000, 5'b11010};
        rm_illegal  = is_round && ((req_rm == 3'b101) || (req_rm == 3'b110) ||
                                   ((req_rm == 3'b111) && (frm_q >= 3'd5)));
        rm_resolved = (is_round && (req_rm == 3'b111)) ? frm_q : req_rm;

        // flush overrides fpu_done in the same cycle.
        capture = (state_q == S_BUSY) && !flush && fpu_done;

        state_d   = state_q;
        op_d      = op_q;
        rm_d      = rm_q;
        a_d       = a_q;
        b_d       = b_q;
        rs2_d     = rs2_q;
        data_d    = data_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;

        frm_d    = csr_frm_we ? csr_wdata[7:5] : frm_q;
        fflags_d = fflags_q | (capture ? fpu_flags : 5'b0);
        // A CSR write that coincides with a capture still keeps the new flags.
        if (csr_fflags_we) begin
            fflags_d = csr_wdata[4:0] | (capture ? fpu_flags : 5'b0);
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d      = req_op;
                    rm_d      = rm_resolved;
                    a_d       = req_a;
                    b_d       = req_b;
                    rs2_d     = req_rs2_lsb;
                    data_d    = 32'd0;
                    flags_d   = 5'd0;
                    illegal_d = rm_illegal;
                    timeout_d = 1'b0;
                    wdog_d    = '0;
                    state_d   = rm_illegal ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + 1'b1;
                if (flush) begin
                    wdog_d  = '0;
                    state_d = S_IDLE;
                end else if (fpu_done) begin
                    data_d  = fpu_result;
                    flags_d = fpu_flags;
                    state_d = S_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || resp_ready) begin
                    wdog_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 5'd0;
            rm_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rs2_q     <= 1'b0;
            data_q    <= 32'd0;
            flags_q   <= 5'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            fflags_q  <= 5'd0;
            frm_q     <= 3'd0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rm_q      <= rm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rs2_q     <= rs2_d;
            data_q    <= data_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            fflags_q  <= fflags_d;
            frm_q     <= frm_d;
            wdog_q    <= wdog_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign fpu_start    = (state_q == S_BUSY);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = data_q;
    assign resp_flags   = flags_q;
    assign resp_illegal = illegal_q;
    assign resp_timeout = timeout_q;
    assign fpu_op       = op_q;
    assign fpu_rm       = rm_q;
    assign fpu_a        = a_q;
    assign fpu_b        = b_q;
    assign fpu_rs2_lsb  = rs2_q;
    assign fflags       = fflags_q;
    assign frm          = frm_q;

endmodule

// File: tb/tb_fpu_arith_ctrl.sv
module tb_fpu_arith_ctrl;

  localparam int TW = 4;
  localparam int WDOG_CYCLES = (1 << TW) - 1;

  localparam logic [4:0] ROUND_OPS [7] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                           5'b01011, 5'b11000, 5'b11010};
  localparam logic [4:0] ALL_OPS [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                          5'b01011, 5'b11000, 5'b11010, 5'b10100,
                                          5'b00100, 5'b00101};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rm;
  logic        req_rs2_lsb;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_flags;
  logic        resp_illegal, resp_timeout;
  logic        flush;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_result;
  logic        fpu_done;
  logic        fpu_overflow, fpu_underflow, fpu_invalid, fpu_inexact, fpu_div_by_zero;
  logic        csr_fflags_we, csr_frm_we;
  logic [7:0]  csr_wdata;
  logic [4:0]  fflags;
  logic [2:0]  frm;

  int checks = 0;
  int failures = 0;

  // Architectural model state of fcsr.
  logic [4:0] m_fflags;
  logic [2:0] m_frm;

  // Per-transaction knobs.
  int         g_bp;
  int         g_flush_at;
  bit         g_flush_resp;
  bit         g_csr_col;
  logic [4:0] g_csr_val;
  bit         g_acc_frm_we;
  logic [2:0] g_acc_frm_val;

  fpu_arith_ctrl #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_rs2_lsb(req_rs2_lsb),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_flags(resp_flags),
    .resp_illegal(resp_illegal), .resp_timeout(resp_timeout),
    .flush(flush),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb),
    .fpu_result(fpu_result), .fpu_done(fpu_done),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
    .fpu_invalid(fpu_invalid), .fpu_inexact(fpu_inexact),
    .fpu_div_by_zero(fpu_div_by_zero),
    .csr_fflags_we(csr_fflags_we), .csr_frm_we(csr_frm_we),
    .csr_wdata(csr_wdata), .fflags(fflags), .frm(frm)
  );

  // Clock and global time bound.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish within time bound");
    $fatal(1, "time bound expired");
  end

  // Checker.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit is_rounding(input logic [4:0] op);
    foreach (ROUND_OPS[i]) if (ROUND_OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_knobs();
    g_bp = 0; g_flush_at = 0; g_flush_resp = 0;
    g_csr_col = 0; g_csr_val = 5'd0; g_acc_frm_we = 0; g_acc_frm_val = 3'd0;
  endtask

  task automatic set_fpu_flags(input logic [4:0] f);
    {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact} = f;
  endtask

  task automatic csr_write(input bit fwe, input bit rwe, input logic [7:0] d);
    csr_fflags_we = fwe; csr_frm_we = rwe; csr_wdata = d;
    step();
    csr_fflags_we = 0; csr_frm_we = 0;
    if (fwe) m_fflags = d[4:0];
    if (rwe) m_frm = d[7:5];
    chk("csr_fflags", fflags, m_fflags);
    chk("csr_frm", frm, m_frm);
  endtask

  // One complete transaction. lat = BUSY cycle on which fpu_done rises (0 = never).
  task automatic op_txn(input logic [4:0] op, input logic [2:0] rm, input logic rs2,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] res, input logic [4:0] fl);
    bit         round, illegal, exp_resp, exp_to, busy, fl_now, done_now, cap;
    logic [2:0] exp_rm;
    logic [31:0] exp_data;
    logic [4:0] exp_flags;
    int         n;

    chk("idle_req_ready", req_ready, 1);
    round   = is_rounding(op);
    exp_rm  = (round && rm == 3'b111) ? m_frm : rm;
    illegal = round && (rm == 3'b101 || rm == 3'b110 || (rm == 3'b111 && m_frm >= 3'd5));

    req_op = op; req_rm = rm; req_rs2_lsb = rs2; req_a = a; req_b = b; req_valid = 1;
    if (g_acc_frm_we) begin
      csr_frm_we = 1; csr_wdata = {g_acc_frm_val, 5'b0};
    end
    step();
    req_valid = 0; csr_frm_we = 0;
    if (g_acc_frm_we) m_frm = g_acc_frm_val;
    chk("frm_after_accept", frm, m_frm);

    exp_resp = 1; exp_to = 0; exp_data = 0; exp_flags = 0;
    if (!illegal) begin
      n = 0; busy = 1;
      while (busy) begin
        n++;
        chk("busy_start", fpu_start, 1);
        chk("busy_resp_valid", resp_valid, 0);
        chk("busy_req_ready", req_ready, 0);
        if (n == 1) begin
          chk("fpu_op", fpu_op, op);
          chk("fpu_rm", fpu_rm, exp_rm);
          chk("fpu_a", fpu_a, a);
          chk("fpu_b", fpu_b, b);
          chk("fpu_rs2_lsb", fpu_rs2_lsb, rs2);
        end
        fl_now   = (n == g_flush_at);
        done_now = (lat != 0) && (n == lat);
        cap      = done_now && !fl_now;
        flush    = fl_now;
        fpu_done = done_now;
        fpu_result = done_now ? res : $urandom;
        set_fpu_flags(done_now ? fl : 5'($urandom));
        if (done_now && g_csr_col) begin
          csr_fflags_we = 1; csr_wdata = {3'b000, g_csr_val};
        end
        step();
        flush = 0; fpu_done = 0; csr_fflags_we = 0;
        if (done_now && g_csr_col) m_fflags = g_csr_val | (cap ? fl : 5'd0);
        else if (cap) m_fflags = m_fflags | fl;
        if (fl_now) begin
          exp_resp = 0; busy = 0;
        end else if (done_now) begin
          exp_data = res; exp_flags = fl; busy = 0;
        end else if (n == WDOG_CYCLES) begin
          exp_to = 1; busy = 0;
        end
      end
    end else begin
      chk("illegal_no_start", fpu_start, 0);
    end

    if (!exp_resp) begin
      chk("flush_idle_ready", req_ready, 1);
      chk("flush_no_resp", resp_valid, 0);
      chk("flush_no_start", fpu_start, 0);
      chk("flush_fflags", fflags, m_fflags);
      return;
    end

    for (int k = 0; k <= g_bp; k++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_data", resp_data, exp_data);
      chk("resp_flags", resp_flags, exp_flags);
      chk("resp_illegal", resp_illegal, illegal);
      chk("resp_timeout", resp_timeout, exp_to);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_no_start", fpu_start, 0);
      chk("resp_fflags", fflags, m_fflags);
      if (k < g_bp) begin
        resp_ready = 0;
        req_valid = 1; req_op = 5'b00000; req_rm = 3'b000; req_a = $urandom; req_b = $urandom;
        step();
      end
    end
    req_valid = 0;
    if (g_flush_resp) begin
      flush = 1; resp_ready = 0;
    end else begin
      resp_ready = 1;
    end
    step();
    flush = 0; resp_ready = 0;
    chk("post_resp_ready", req_ready, 1);
    chk("post_resp_valid", resp_valid, 0);
    chk("post_fflags", fflags, m_fflags);
  endtask

  initial begin
    reset = 1; req_valid = 0; req_op = 0; req_rm = 0; req_rs2_lsb = 0; req_a = 0; req_b = 0;
    resp_ready = 0; flush = 0; fpu_result = 0; fpu_done = 0; set_fpu_flags(5'd0);
    csr_fflags_we = 0; csr_frm_we = 0; csr_wdata = 0;
    m_fflags = 0; m_frm = 0;
    clear_knobs();
    @(negedge clk);
    step();
    // Reset state.
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_frm", frm, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_fpu_a", fpu_a, 0);
    reset = 0;
    step();

    // FADD 1.0 + 2.0, single-cycle.
    op_txn(5'b00000, 3'b000, 0, 32'h3F800000, 32'h40000000, 1, 32'h40400000, 5'b00000);
    chk("fadd_fflags", fflags, 5'b00000);

    // FDIV by zero, 10-cycle latency, then an inexact FADD.
    op_txn(5'b00011, 3'b000, 0, 32'h3F800000, 32'h00000000, 10, 32'h7F800000, 5'b01000);
    chk("fdiv_fflags", fflags, 5'b01000);
    op_txn(5'b00000, 3'b000, 0, 32'h3F800000, 32'h33800000, 1, 32'h3F800000, 5'b00001);
    chk("accrue_fflags", fflags, 5'b01001);

    // Dynamic rounding and pass-through rm.
    csr_write(0, 1, {3'b001, 5'b0});
    op_txn(5'b00000, 3'b111, 0, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 5'b00000);
    op_txn(5'b10100, 3'b010, 0, 32'h3F800000, 32'h3F800000, 1, 32'h00000001, 5'b00000);
    csr_write(0, 1, {3'b101, 5'b0});
    op_txn(5'b00001, 3'b111, 0, 32'h3F800000, 32'h3F800000, 1, 32'h0, 5'b00000);
    chk("illegal_fflags", fflags, 5'b01001);
    op_txn(5'b00010, 3'b110, 0, 32'h1, 32'h2, 1, 32'h0, 5'b00000);

    // Backpressure with a stray request during RESP.
    g_bp = 3;
    op_txn(5'b00010, 3'b000, 0, 32'h40000000, 32'h40400000, 4, 32'h40C00000, 5'b00000);
    clear_knobs();

    // Flush in cycle 3 of a 10-cycle FDIV, flush colliding with done, flush in RESP.
    g_flush_at = 3;
    op_txn(5'b00011, 3'b000, 0, 32'h3F800000, 32'h40400000, 10, 32'h3EAAAAAB, 5'b00001);
    g_flush_at = 5;
    op_txn(5'b00011, 3'b000, 0, 32'h3F800000, 32'h40400000, 5, 32'h3EAAAAAB, 5'b00001);
    clear_knobs();
    g_flush_resp = 1;
    op_txn(5'b00000, 3'b000, 0, 32'h3F800000, 32'h3F800000, 2, 32'h40000000, 5'b10000);
    clear_knobs();

    // Watchdog.
    op_txn(5'b00011, 3'b000, 0, 32'h3F800000, 32'h40400000, 0, 32'h0, 5'b00000);

    // fflags write colliding with a capture.
    csr_write(1, 0, 8'h00);
    g_csr_col = 1; g_csr_val = 5'b00100;
    op_txn(5'b00000, 3'b000, 0, 32'h3F800000, 32'h33800000, 1, 32'h3F800000, 5'b00001);
    chk("collide_fflags", fflags, 5'b00101);
    clear_knobs();

    // frm write in the accept cycle: old frm resolves the request.
    csr_write(0, 1, {3'b010, 5'b0});
    g_acc_frm_we = 1; g_acc_frm_val = 3'b011;
    op_txn(5'b00000, 3'b111, 0, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 5'b00000);
    clear_knobs();

    // Flush in IDLE blocks an accept.
    req_valid = 1; req_op = 5'b00000; req_rm = 3'b000; flush = 1;
    step();
    req_valid = 0; flush = 0;
    chk("idle_flush_ready", req_ready, 1);
    chk("idle_flush_start", fpu_start, 0);
    chk("idle_flush_resp", resp_valid, 0);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      logic [4:0] op;
      int lat;
      clear_knobs();
      if ($urandom_range(0, 2) == 0)
        csr_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      op  = ALL_OPS[$urandom_range(0, 9)];
      lat = $urandom_range(1, 8);
      g_bp = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) g_flush_at = $urandom_range(1, lat);
      if ($urandom_range(0, 7) == 0) g_flush_resp = 1;
      if ($urandom_range(0, 4) == 0) begin
        g_csr_col = 1; g_csr_val = 5'($urandom);
      end
      op_txn(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             lat, $urandom, 5'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
